// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner_pkg
//  Description : Shared constants for the input conditioner. Holds the
//                channel debounce FSM state encoding, the default timing
//                constants, the board key indices and the counter width
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_conditioner_pkg;

    // Default timing at 50 MHz: 10 ms debounce, 0.5 s hold
    localparam int unsigned c_DEFAULT_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned c_DEFAULT_HOLD_CYCLES     = 25_000_000;

    // Board key indices within key_n
    localparam int unsigned c_KEY_START = 0;
    localparam int unsigned c_KEY_PAUSE = 1;
    localparam int unsigned c_NUM_KEYS  = 2;

    // Channel debounce FSM state encoding
    localparam int unsigned c_STATE_W      = 2;
    localparam logic [1:0]  c_ST_RELEASED    = 2'd0;
    localparam logic [1:0]  c_ST_ARM_PRESS   = 2'd1;
    localparam logic [1:0]  c_ST_PRESSED     = 2'd2;
    localparam logic [1:0]  c_ST_ARM_RELEASE = 2'd3;

    // Counter width large enough to hold the larger of the two cycle limits
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage : input_conditioner_pkg
`default_nettype wire

// File: rtl/input_conditioner_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One conditioned input channel: 2-flop synchronizer, four
//                state debounce FSM with saturating stability counter, a
//                one-cycle press pulse and the debounced level. The synced
//                raw value is exported so the parent can change polarity
//                before it reaches the FSM on i_active.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = cnt_width(c_DEFAULT_DEBOUNCE_CYCLES,
                                                       c_DEFAULT_HOLD_CYCLES),
    parameter logic        SYNC_RESET_VAL  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_sync,
    input  logic i_active,
    output logic o_press,
    output logic o_level
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]           r_sync;
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_press;
    logic                 w_press_nxt;

    // Two-flop synchronizer; resets to the channel's released raw level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= {2{SYNC_RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    assign o_sync = r_sync[1];

    // Next-state logic: a level change is accepted only after it stays stable
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        case (r_state)
            c_ST_RELEASED: begin
                if (i_active) begin
                    w_state_nxt = c_ST_ARM_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_ARM_PRESS: begin
                if (!i_active) begin
                    w_state_nxt = c_ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_PRESSED;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_PRESSED: begin
                if (!i_active) begin
                    w_state_nxt = c_ST_ARM_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_ARM_RELEASE: begin
                if (i_active) begin
                    w_state_nxt = c_ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and press-pulse registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_RELEASED;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    assign o_press = r_press;
    assign o_level = (r_state == c_ST_PRESSED) || (r_state == c_ST_ARM_RELEASE);

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Debounces two active-low board keys (start, pause) and
//                NUM_PADS active-high dance-pad contacts. Produces one-cycle
//                start/pause strobes, per-pad press pulses and debounced
//                levels. Macro INPUT_CONDITIONER_HOLD_EN adds the pad_hold
//                output, asserted once a pad has been down HOLD_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = c_DEFAULT_HOLD_CYCLES,
    parameter int unsigned NUM_PADS        = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          key_n,
    input  logic [NUM_PADS-1:0] pad_raw,
    output logic                start_n,
    output logic                pause_n,
    output logic [NUM_PADS-1:0] pad_press,
    output logic [NUM_PADS-1:0] pad_level
`ifdef INPUT_CONDITIONER_HOLD_EN
   ,output logic [NUM_PADS-1:0] pad_hold
`endif
);

    localparam int unsigned c_CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);

    logic [c_NUM_KEYS-1:0] w_key_sync;
    logic [c_NUM_KEYS-1:0] w_key_active;
    logic [c_NUM_KEYS-1:0] w_key_press;
    logic [c_NUM_KEYS-1:0] w_key_level;
    logic [NUM_PADS-1:0]   w_pad_sync;

    // Key channels: synchronizers idle high, inverted to active-high after sync
    for (genvar k = 0; k < c_NUM_KEYS; k++) begin : g_key
        assign w_key_active[k] = ~w_key_sync[k];

        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (c_CNT_W),
            .SYNC_RESET_VAL  (1'b1)
        ) u_key_chan (
            .clock    (clock),
            .reset    (reset),
            .i_raw    (key_n[k]),
            .o_sync   (w_key_sync[k]),
            .i_active (w_key_active[k]),
            .o_press  (w_key_press[k]),
            .o_level  (w_key_level[k])
        );
    end

    // Pad channels: already active-high, synced value drives the FSM directly
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (c_CNT_W),
            .SYNC_RESET_VAL  (1'b0)
        ) u_pad_chan (
            .clock    (clock),
            .reset    (reset),
            .i_raw    (pad_raw[p]),
            .o_sync   (w_pad_sync[p]),
            .i_active (w_pad_sync[p]),
            .o_press  (pad_press[p]),
            .o_level  (pad_level[p])
        );
    end

    // A press pulse only fires on entry to the pressed level, so qualifying
    // it with the level is a no-op that keeps the key levels in use
    assign start_n = ~(w_key_press[c_KEY_START] & w_key_level[c_KEY_START]);
    assign pause_n = ~(w_key_press[c_KEY_PAUSE] & w_key_level[c_KEY_PAUSE]);

`ifdef INPUT_CONDITIONER_HOLD_EN
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES);
    localparam logic [c_CNT_W-1:0] c_HOLD_ONE  = c_CNT_W'(1);

    for (genvar h = 0; h < NUM_PADS; h++) begin : g_hold
        logic [c_CNT_W-1:0] r_hold_cnt;

        // Count cycles of debounced press, saturating at the hold threshold
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_hold_cnt <= '0;
            end else if (!pad_level[h]) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != c_HOLD_LAST) begin
                r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
            end
        end

        // Gated by level so hold drops in the same cycle the level falls
        assign pad_hold[h] = pad_level[h] & (r_hold_cnt == c_HOLD_LAST);
    end
`endif

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_conditioner
//  Description : Self-checking bench for input_conditioner with
//                DEBOUNCE_CYCLES=4, HOLD_CYCLES=10. A reference model
//                computes expected outputs each edge into a queue; a monitor
//                pops and compares on the falling edge. Directed scenarios
//                add explicit latency and pulse-count checks. Hold checks are
//                built when INPUT_CONDITIONER_HOLD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    localparam int c_D   = 4;
    localparam int c_H   = 10;
    localparam int c_NP  = 8;
    localparam int c_NCH = c_NP + 2;

    logic            clock   = 1'b0;
    logic            reset   = 1'b1;
    logic [1:0]      key_n   = 2'b11;
    logic [c_NP-1:0] pad_raw = '0;
    logic            start_n;
    logic            pause_n;
    logic [c_NP-1:0] pad_press;
    logic [c_NP-1:0] pad_level;
`ifdef INPUT_CONDITIONER_HOLD_EN
    logic [c_NP-1:0] pad_hold;
`endif

    input_conditioner #(
        .DEBOUNCE_CYCLES (c_D),
        .HOLD_CYCLES     (c_H),
        .NUM_PADS        (c_NP)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_n),
        .pad_raw   (pad_raw),
        .start_n   (start_n),
        .pause_n   (pause_n),
        .pad_press (pad_press),
        .pad_level (pad_level)
`ifdef INPUT_CONDITIONER_HOLD_EN
       ,.pad_hold  (pad_hold)
`endif
    );

    always #10 clock = ~clock;

    typedef struct packed {
        logic            start_n;
        logic            pause_n;
        logic [c_NP-1:0] press;
        logic [c_NP-1:0] level;
        logic [c_NP-1:0] hold;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;

    // Reference model: accepted level per channel flips once the synchronized
    // input has disagreed with it for D+1 consecutive edges
    bit m_s1  [c_NCH];
    bit m_s2  [c_NCH];
    bit m_lvl [c_NCH];
    int m_run [c_NCH];
    int m_since [c_NP];

    // Stimulus currently applied by tick()
    logic [1:0]      cur_key = 2'b11;
    logic [c_NP-1:0] cur_pad = '0;
    logic            cur_rst = 1'b1;

    // Observation counters for directed checks
    int        w_edge, w_first_start, w_first_press, w_n_start, w_n_pause, w_n_all;
    int        w_n_press [c_NP];
    logic [c_NP-1:0] w_lvl_any;

    function automatic void model_step();
        exp_t e;
        bit   prev;
        bit   pulse;
        e = '0;
        e.start_n = 1'b1;
        e.pause_n = 1'b1;
        if (reset) begin
            for (int ch = 0; ch < c_NCH; ch++) begin
                m_s1[ch] = 0; m_s2[ch] = 0; m_lvl[ch] = 0; m_run[ch] = 0;
            end
            for (int p = 0; p < c_NP; p++) m_since[p] = 0;
        end else begin
            for (int ch = 0; ch < c_NCH; ch++) begin
                pulse = 0;
                prev  = m_lvl[ch];
                if (m_s2[ch] != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == c_D + 1) begin
                        m_lvl[ch] = ~m_lvl[ch];
                        m_run[ch] = 0;
                        pulse     = m_lvl[ch];
                    end
                end else begin
                    m_run[ch] = 0;
                end
                m_s2[ch] = m_s1[ch];
                if (ch < 2) m_s1[ch] = ~key_n[ch];
                else        m_s1[ch] = pad_raw[ch-2];
                if (ch == 0)      e.start_n = ~pulse;
                else if (ch == 1) e.pause_n = ~pulse;
                else begin
                    e.press[ch-2] = pulse;
                    e.level[ch-2] = m_lvl[ch];
                    if (!m_lvl[ch] || !prev) m_since[ch-2] = 0;
                    else if (m_since[ch-2] < c_H) m_since[ch-2]++;
                    e.hold[ch-2] = m_lvl[ch] && (m_since[ch-2] >= c_H);
                end
            end
        end
        q_exp.push_back(e);
    endfunction

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        exp_t a;
        if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            a.start_n = start_n;
            a.pause_n = pause_n;
            a.press   = pad_press;
            a.level   = pad_level;
`ifdef INPUT_CONDITIONER_HOLD_EN
            a.hold    = pad_hold;
`else
            a.hold    = '0;
            e.hold    = '0;
`endif
            n_cycle++;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard cycle %0d: got start_n=%b pause_n=%b press=%h level=%h hold=%h, expected start_n=%b pause_n=%b press=%h level=%h hold=%h",
                         n_cycle, a.start_n, a.pause_n, a.press, a.level, a.hold,
                         e.start_n, e.pause_n, e.press, e.level, e.hold);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply current stimulus away from the rising edge, then model that edge
    task automatic tick();
        @(negedge clock);
        #1;
        key_n   = cur_key;
        pad_raw = cur_pad;
        reset   = cur_rst;
        @(posedge clock);
        model_step();
    endtask

    task automatic clear_watch();
        w_edge = 0; w_first_start = -1; w_first_press = -1;
        w_n_start = 0; w_n_pause = 0; w_n_all = 0; w_lvl_any = '0;
        for (int b = 0; b < c_NP; b++) w_n_press[b] = 0;
    endtask

    task automatic run_watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            #1;
            w_edge++;
            if (!start_n) begin
                w_n_start++;
                if (w_first_start < 0) w_first_start = w_edge;
            end
            if (!pause_n) w_n_pause++;
            if (pad_press != '0 && w_first_press < 0) w_first_press = w_edge;
            for (int b = 0; b < c_NP; b++) if (pad_press[b]) w_n_press[b]++;
            if (!start_n && !pause_n && pad_press == 8'hFF) w_n_all++;
            w_lvl_any |= pad_level;
        end
    endtask

    initial begin
        int t_lvl, t_hold;
        t_lvl  = -1;
        t_hold = -1;

        // Reset state
        cur_rst = 1'b1;
        clear_watch();
        run_watch(3);
        check("reset_outputs", int'({start_n, pause_n, pad_press, pad_level}),
              int'({1'b1, 1'b1, 8'h00, 8'h00}));
        cur_rst = 1'b0;
        run_watch(5);

        // Start key pressed and held: one strobe, 7 edges after the edge
        cur_key = 2'b10;
        clear_watch();
        run_watch(30);
        check("start_latency", w_first_start, 7);
        check("start_pulse_count", w_n_start, 1);
        cur_key = 2'b11;
        run_watch(10);

        // Three-cycle glitch on pad 2 is rejected
        clear_watch();
        cur_pad = 8'h04;
        run_watch(3);
        cur_pad = 8'h00;
        run_watch(10);
        check("glitch_press_count", w_n_press[2], 0);
        check("glitch_level", int'(w_lvl_any[2]), 0);

        // Pad 5 bounces, then settles pressed; release bounce gives no pulse
        clear_watch();
        for (int i = 0; i < 4; i++) begin
            cur_pad = (i % 2 == 0) ? 8'h20 : 8'h00;
            run_watch(1);
        end
        cur_pad = 8'h20;
        run_watch(12);
        check("bounce_press_count", w_n_press[5], 1);
        check("bounce_level_high", int'(pad_level[5]), 1);
        clear_watch();
        for (int i = 0; i < 4; i++) begin
            cur_pad = (i % 2 == 0) ? 8'h00 : 8'h20;
            run_watch(1);
        end
        cur_pad = 8'h00;
        run_watch(12);
        check("release_press_count", w_n_press[5], 0);
        check("release_level_low", int'(pad_level[5]), 0);

        // Everything pressed in one cycle: all pulses coincide
        clear_watch();
        cur_key = 2'b00;
        cur_pad = 8'hFF;
        run_watch(15);
        check("all_same_cycle", w_n_all, 1);
        check("all_start_count", w_n_start, 1);
        check("all_pause_count", w_n_pause, 1);
        check("all_latency", w_first_press, 7);
        cur_key = 2'b11;
        cur_pad = 8'h00;
        run_watch(12);

        // Reset in the middle of a debounce, input still held
        clear_watch();
        cur_pad = 8'h02;
        run_watch(5);
        cur_rst = 1'b1;
        run_watch(2);
        check("midreset_no_pulse", w_n_press[1], 0);
        cur_rst = 1'b0;
        clear_watch();
        run_watch(15);
        check("postreset_latency", w_first_press, 7);
        check("postreset_count", w_n_press[1], 1);
        cur_pad = 8'h00;
        run_watch(12);

`ifdef INPUT_CONDITIONER_HOLD_EN
        // Hold rises 10 cycles after level, falls together with it
        cur_pad = 8'h01;
        for (int i = 1; i <= 25; i++) begin
            tick(); #1;
            if (pad_level[0] && t_lvl < 0) t_lvl = i;
            if (pad_hold[0] && t_hold < 0) t_hold = i;
        end
        check("hold_level_rise", t_lvl, 7);
        check("hold_rise", t_hold, 17);
        cur_pad = 8'h00;
        t_lvl = -1; t_hold = -1;
        for (int i = 1; i <= 15; i++) begin
            tick(); #1;
            if (!pad_level[0] && t_lvl < 0) t_lvl = i;
            if (!pad_hold[0] && t_hold < 0) t_hold = i;
        end
        check("hold_level_fall", t_lvl, 7);
        check("hold_fall", t_hold, 7);
`endif

        // Randomized inputs and occasional resets, checked by the model
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 2; b++) if ($urandom_range(4) == 0) cur_key[b] = ~cur_key[b];
            for (int b = 0; b < c_NP; b++) if ($urandom_range(4) == 0) cur_pad[b] = ~cur_pad[b];
            if (i % 500 == 250) begin
                cur_key = 2'b00;
                cur_pad = 8'hFF;
            end
            cur_rst = ($urandom_range(299) == 0);
            tick();
        end
        cur_rst = 1'b0;
        cur_key = 2'b11;
        cur_pad = 8'h00;
        for (int i = 0; i < 20; i++) tick();
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_input_conditioner
`default_nettype wire
